// File: rtl/multicycle_ctrl_fsm.sv
// Control sequencer for the multicycle ARM datapath.
// A Moore FSM steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
// It owns the held NZCV flags and drives every datapath select and enable
// from registers that are loaded with the decode of the state being entered.
module multicycle_ctrl_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] RegSrc,
   output logic [2:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic [3:0] Flags
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_MOV = 3'b100;

   localparam logic [3:0] CMD_CMP = 4'b1010;

   // Every control output in one bundle so a whole state decode is one value.
   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] reg_src;
      logic [2:0] imm_src;
      logic [2:0] alu_control;
   } ctrl_t;

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_flags;
   ctrl_t      r_ctrl;
   logic       w_cond_ok;
   logic       w_is_cmp;
   logic       w_arith;
   logic       w_in_exec;

   // ARM condition check against held NZCV; 1111 never executes.
   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      logic res;
      {n, z, cf, v} = f;
      case (c)
         4'b0000: res = z;
         4'b0001: res = ~z;
         4'b0010: res = cf;
         4'b0011: res = ~cf;
         4'b0100: res = n;
         4'b0101: res = ~n;
         4'b0110: res = v;
         4'b0111: res = ~v;
         4'b1000: res = cf & ~z;
         4'b1001: res = ~cf | z;
         4'b1010: res = (n == v);
         4'b1011: res = (n != v);
         4'b1100: res = ~z & (n == v);
         4'b1101: res = z | (n != v);
         4'b1110: res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Data-processing command to ALU operation; unlisted commands add.
   function automatic logic [2:0] alu_for_cmd(input logic [3:0] cmd);
      logic [2:0] a;
      case (cmd)
         4'b0100: a = ALU_ADD;
         4'b0010: a = ALU_SUB;
         4'b1010: a = ALU_SUB;
         4'b0000: a = ALU_AND;
         4'b1100: a = ALU_ORR;
         4'b1101: a = ALU_MOV;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

   // Control values seen while sitting in state s; anything not named stays 0.
   function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] fn, input logic [3:0] rd);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.pc_write   = 1'b1;
            c.ir_write   = 1'b1;
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_DECODE: begin
            c.alu_src_a  = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
            c.reg_src    = 2'b10;
         end
         S_MEMADR: begin
            c.alu_src_b   = 2'b01;
            c.imm_src     = 3'b001;
            c.alu_control = fn[3] ? ALU_ADD : ALU_SUB;
         end
         S_MEMRD: begin
            c.adr_src = 1'b1;
         end
         S_MEMWB: begin
            // A load into R15 becomes a jump instead of a register write.
            c.result_src = 2'b01;
            c.reg_write  = (rd != 4'd15);
            c.pc_write   = (rd == 4'd15);
         end
         S_MEMWR: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
            c.reg_src   = 2'b10;
         end
         S_EXECR: begin
            c.alu_control = alu_for_cmd(fn[4:1]);
         end
         S_EXECI: begin
            c.alu_src_b   = 2'b01;
            c.alu_control = alu_for_cmd(fn[4:1]);
         end
         S_ALUWB: begin
            c.reg_write = (rd != 4'd15);
            c.pc_write  = (rd == 4'd15);
         end
         S_BRANCH: begin
            c.pc_write   = 1'b1;
            c.reg_src    = 2'b01;
            c.alu_src_b  = 2'b01;
            c.imm_src    = 3'b010;
            c.result_src = 2'b10;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   assign w_cond_ok = cond_holds(Cond, r_flags);
   assign w_is_cmp  = (Funct[4:1] == CMD_CMP);
   assign w_arith   = (alu_for_cmd(Funct[4:1]) == ALU_ADD) || (alu_for_cmd(Funct[4:1]) == ALU_SUB);
   assign w_in_exec = (r_state == S_EXECR) || (r_state == S_EXECI);

   // Next-state selection from current state and latched instruction fields.
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            if (!w_cond_ok) begin
               w_next = S_FETCH;
            end else begin
               case (Op)
                  2'b01:   w_next = S_MEMADR;
                  2'b10:   w_next = S_BRANCH;
                  2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
                  default: w_next = S_FETCH;
               endcase
            end
         end
         S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_next = S_MEMWB;
         S_EXECR,
         S_EXECI:  w_next = w_is_cmp ? S_FETCH : S_ALUWB;
         default:  w_next = S_FETCH;
      endcase
   end

   // State, held flags and registered control outputs advance together.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_flags <= 4'b0000;
         r_ctrl  <= ctrl_for(S_FETCH, 6'd0, 4'd0);
      end else begin
         r_state <= w_next;
         r_ctrl  <= ctrl_for(w_next, Funct, Rd);
         // Logical ops leave C and V alone; compares always update flags.
         if (w_in_exec && (Funct[0] || w_is_cmp)) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (w_arith) begin
               r_flags[1:0] <= ALUFlags[1:0];
            end
         end
      end
   end

   assign PCWrite    = r_ctrl.pc_write;
   assign AdrSrc     = r_ctrl.adr_src;
   assign MemWrite   = r_ctrl.mem_write;
   assign IRWrite    = r_ctrl.ir_write;
   assign RegWrite   = r_ctrl.reg_write;
   assign ResultSrc  = r_ctrl.result_src;
   assign ALUSrcA    = r_ctrl.alu_src_a;
   assign ALUSrcB    = r_ctrl.alu_src_b;
   assign RegSrc     = r_ctrl.reg_src;
   assign ImmSrc     = r_ctrl.imm_src;
   assign ALUControl = r_ctrl.alu_control;
   assign Flags      = r_flags;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed ARM instructions plus random
// instruction streams compared cycle by cycle against an instruction-level model.
module tb_multicycle_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] Cond = 4'b0;
   logic [1:0] Op = 2'b0;
   logic [5:0] Funct = 6'b0;
   logic [3:0] Rd = 4'b0;
   logic [3:0] ALUFlags = 4'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0] ResultSrc, ALUSrcB, RegSrc;
   logic [2:0] ImmSrc, ALUControl;
   logic [3:0] Flags;

   multicycle_ctrl_fsm dut (
      .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
      .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .Flags(Flags)
   );

   always #5 clk = ~clk;

   // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,RegSrc,ImmSrc,ALUControl}
   logic [17:0] dut_vec;
   assign dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                     ALUSrcB, RegSrc, ImmSrc, ALUControl};

   localparam int C_NOP = 0, C_BR = 1, C_LDR = 2, C_STR = 3, C_DP = 4, C_CMP = 5;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [17:0] exp_ctrl = '0;
   logic [3:0]  exp_flags = '0;
   bit          exp_valid = 1'b0;
   bit          done = 1'b0;
   logic [3:0]  m_flags = '0;
   logic [17:0] obs [0:7];

   function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
      logic base;
      case (c[3:1])
         3'd0: base = f[2];
         3'd1: base = f[1];
         3'd2: base = f[3];
         3'd3: base = f[0];
         3'd4: base = f[1] & ~f[2];
         3'd5: base = (f[3] == f[0]);
         3'd6: base = ~f[2] & (f[3] == f[0]);
         default: return (c == 4'b1110);
      endcase
      return base ^ c[0];
   endfunction

   function automatic int classify(input logic [3:0] c, input logic [1:0] o,
                                   input logic [5:0] fn, input logic [3:0] fl);
      if (!m_cond(c, fl)) return C_NOP;
      if (o == 2'd1) return fn[0] ? C_LDR : C_STR;
      if (o == 2'd2) return C_BR;
      if (o == 2'd0) return (fn[4:1] == 4'b1010) ? C_CMP : C_DP;
      return C_NOP;
   endfunction

   function automatic int len_of(input int cls);
      case (cls)
         C_NOP: return 2;
         C_BR, C_CMP: return 3;
         C_STR, C_DP: return 4;
         default: return 5;
      endcase
   endfunction

   function automatic logic [2:0] m_alu(input logic [3:0] cmd);
      if (cmd == 4'b0010 || cmd == 4'b1010) return 3'd1;
      if (cmd == 4'b0000) return 3'd2;
      if (cmd == 4'b1100) return 3'd3;
      if (cmd == 4'b1101) return 3'd4;
      return 3'd0;
   endfunction

   // Expected outputs for cycle k of an instruction of class cls.
   function automatic logic [17:0] exp_vec(input int cls, input int k,
                                           input logic [5:0] fn, input logic [3:0] rd);
      logic pcw, adr, mw, irw, rw, sa;
      logic [1:0] rs, sb, rsrc;
      logic [2:0] imm, alu;
      {pcw, adr, mw, irw, rw, sa} = '0;
      {rs, sb, rsrc} = '0;
      {imm, alu} = '0;
      if (k == 0) begin
         pcw = 1; irw = 1; sa = 1; sb = 2'b10; rs = 2'b10;
      end else if (k == 1) begin
         sa = 1; sb = 2'b10; rs = 2'b10; rsrc = 2'b10;
      end else if (cls == C_BR) begin
         pcw = 1; rsrc = 2'b01; sb = 2'b01; imm = 3'b010; rs = 2'b10;
      end else if (cls == C_LDR || cls == C_STR) begin
         if (k == 2) begin
            sb = 2'b01; imm = 3'b001; alu = fn[3] ? 3'd0 : 3'd1;
         end else if (k == 3) begin
            adr = 1;
            if (cls == C_STR) begin mw = 1; rsrc = 2'b10; end
         end else begin
            rs = 2'b01; rw = (rd != 15); pcw = (rd == 15);
         end
      end else if (k == 2) begin
         sb = fn[5] ? 2'b01 : 2'b00; alu = m_alu(fn[4:1]);
      end else begin
         rw = (rd != 15); pcw = (rd == 15);
      end
      return {pcw, adr, mw, irw, rw, rs, sa, sb, rsrc, imm, alu};
   endfunction

   task automatic chk(input string name, input logic [17:0] act, input logic [17:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // Runs one instruction; abort_k >= 0 pulses reset during that cycle.
   task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] fn,
                            input logic [3:0] rd, input bit fix_af, input logic [3:0] af,
                            input int abort_k);
      int cls, len;
      logic [3:0] cmd;
      cls = classify(c, o, fn, m_flags);
      len = len_of(cls);
      cmd = fn[4:1];
      Cond = c; Op = o; Funct = fn; Rd = rd;
      for (int k = 0; k < len; k++) begin
         exp_ctrl = exp_vec(cls, k, fn, rd);
         exp_flags = m_flags;
         exp_valid = 1'b1;
         ALUFlags = fix_af ? af : 4'($urandom);
         obs[k] = dut_vec;
         if (k == 2 && (cls == C_DP || cls == C_CMP) && (fn[0] || cls == C_CMP)) begin
            m_flags[3:2] = ALUFlags[3:2];
            if (!(cmd == 4'b0000 || cmd == 4'b1100 || cmd == 4'b1101))
               m_flags[1:0] = ALUFlags[1:0];
         end
         if (k == abort_k) reset = 1'b1;
         @(posedge clk); #1;
         if (k == abort_k) begin
            reset = 1'b0;
            m_flags = 4'b0;
            obs[k + 1] = dut_vec;
            return;
         end
      end
      obs[len] = dut_vec;
   endtask

   task automatic run_word(input logic [31:0] w, input bit fix_af, input logic [3:0] af,
                           input int abort_k);
      run_instr(w[31:28], w[27:26], w[25:20], w[15:12], fix_af, af, abort_k);
   endtask

   initial begin
      fork
         begin
            @(posedge clk); @(posedge clk); #1;
            chk("reset_ctrl", dut_vec, 18'h25600);
            chk("reset_flags", {14'd0, Flags}, 18'd0);
            reset = 1'b0;

            // MOV R1,#5
            run_word(32'hE3A0_1005, 1'b0, 4'b0, -1);
            chk("mov_alu_mov", {15'd0, obs[2][2:0]}, 18'd4);
            chk("mov_regwrite_wb", {17'd0, obs[3][13]}, 18'd1);
            chk("mov_no_regwrite_exec", {17'd0, obs[2][13]}, 18'd0);
            chk("mov_back_fetch", {17'd0, obs[4][14]}, 18'd1);
            // CMP R0,#5 with ALUFlags 0110
            run_word(32'hE350_0005, 1'b1, 4'b0110, -1);
            chk("cmp_flags", {14'd0, Flags}, 18'b0110);
            chk("cmp_3cycles", {17'd0, obs[3][14]}, 18'd1);
            // BEQ taken (Z=1)
            run_word(32'h0A00_0002, 1'b0, 4'b0, -1);
            chk("beq_taken_pcw", {17'd0, obs[2][17]}, 18'd1);
            chk("beq_taken_not_fetch", {17'd0, obs[2][14]}, 18'd0);
            // Clear Z, then BEQ not taken
            run_word(32'hE350_0005, 1'b1, 4'b0000, -1);
            run_word(32'h0A00_0002, 1'b0, 4'b0, -1);
            chk("beq_nt_refetch", {17'd0, obs[2][14]}, 18'd1);
            chk("beq_nt_decode_pcw", {17'd0, obs[1][17]}, 18'd0);
            // LDR R2,[R1,#4]
            run_word(32'hE591_2004, 1'b0, 4'b0, -1);
            chk("ldr_adrsrc", {17'd0, obs[3][16]}, 18'd1);
            chk("ldr_resultsrc", {16'd0, obs[4][12:11]}, 18'd1);
            chk("ldr_regwrite", {17'd0, obs[4][13]}, 18'd1);
            // STR
            run_word(32'hE581_2008, 1'b0, 4'b0, -1);
            chk("str_memwrite", {17'd0, obs[3][15]}, 18'd1);
            chk("str_regsrc", {16'd0, obs[3][7:6]}, 18'd2);
            chk("str_memwrite_once", {17'd0, obs[4][15]}, 18'd0);
            // MOV PC,LR
            run_word(32'hE1A0_F00E, 1'b0, 4'b0, -1);
            chk("movpc_pcwrite", {17'd0, obs[3][17]}, 18'd1);
            chk("movpc_no_regwrite", {17'd0, obs[3][13]}, 18'd0);
            // LDR aborted by reset in MEMADR
            run_word(32'hE591_2004, 1'b0, 4'b0, 2);
            chk("abort_fetch", obs[3], 18'h25600);
            chk("abort_flags", {14'd0, Flags}, 18'd0);

            // Random instruction stream
            for (int i = 0; i < 400; i++) begin
               logic [3:0] c, cmd, rd;
               logic [1:0] o;
               logic [5:0] fn;
               int ab;
               c = ($urandom_range(0, 1) == 0) ? 4'b1110 : 4'($urandom);
               o = 2'($urandom);
               case ($urandom_range(0, 6))
                  0: cmd = 4'b0100;
                  1: cmd = 4'b0010;
                  2: cmd = 4'b1010;
                  3: cmd = 4'b0000;
                  4: cmd = 4'b1100;
                  5: cmd = 4'b1101;
                  default: cmd = 4'($urandom);
               endcase
               fn = {1'($urandom), cmd, 1'($urandom)};
               rd = 4'($urandom);
               ab = ($urandom_range(0, 39) == 0) ? $urandom_range(1, 3) : -1;
               run_instr(c, o, fn, rd, 1'b0, 4'b0, ab);
            end
            exp_valid = 1'b0;
            @(posedge clk); #1;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               if (exp_valid) begin
                  n_chk++;
                  if (dut_vec === exp_ctrl) n_pass++;
                  else $display("FAIL ctrl @%0t: got %h expected %h", $time, dut_vec, exp_ctrl);
                  n_chk++;
                  if (Flags === exp_flags) n_pass++;
                  else $display("FAIL flags @%0t: got %b expected %b", $time, Flags, exp_flags);
               end
            end
         end
      join
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
